// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg: ID/EX pipeline register with load-use stall, flush, hold and bubble counter
module id_ex_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              HOLD,
  input  logic              FLUSH,
  input  logic              IN_VALID,
  input  logic [2:0]        MEM_READ_IN,
  input  logic [2:0]        MEM_WRITE_IN,
  input  logic [1:0]        MEM_TO_REG_IN,
  input  logic [1:0]        ALU_SOURCE_IN,
  input  logic [4:0]        ALU_OP_IN,
  input  logic              REG_WRITE_IN,
  input  logic              BRANCH_IN,
  input  logic              PC_SEL_IN,
  input  logic [DATA_W-1:0] PC_IN,
  input  logic [DATA_W-1:0] RS1_DATA_IN,
  input  logic [DATA_W-1:0] RS2_DATA_IN,
  input  logic [DATA_W-1:0] IMM_IN,
  input  logic [4:0]        RD_IN,
  input  logic [4:0]        RS1_IN,
  input  logic [4:0]        RS2_IN,
  output logic [2:0]        MEM_READ_OUT,
  output logic [2:0]        MEM_WRITE_OUT,
  output logic [1:0]        MEM_TO_REG_OUT,
  output logic [1:0]        ALU_SOURCE_OUT,
  output logic [4:0]        ALU_OP_OUT,
  output logic              REG_WRITE_OUT,
  output logic              BRANCH_OUT,
  output logic              PC_SEL_OUT,
  output logic [DATA_W-1:0] PC_OUT,
  output logic [DATA_W-1:0] RS1_DATA_OUT,
  output logic [DATA_W-1:0] RS2_DATA_OUT,
  output logic [DATA_W-1:0] IMM_OUT,
  output logic [4:0]        RD_OUT,
  output logic [4:0]        RS1_OUT,
  output logic [4:0]        RS2_OUT,
  output logic              VALID_OUT,
  output logic              STALL_UP,
  output logic [CNT_W-1:0]  BUBBLE_CNT
);
  localparam int CW = 18;
  localparam int DW = 4 * DATA_W + 15;
  logic [CW-1:0]    r_ctl;
  logic [DW-1:0]    r_dat;
  logic             r_valid;
  logic [CNT_W-1:0] r_cnt;
  logic [CW-1:0]    w_ctl_in;
  logic [DW-1:0]    w_dat_in;
  logic             w_rs2_used;
  logic             w_hazard;
  assign w_ctl_in = {MEM_READ_IN, MEM_WRITE_IN, MEM_TO_REG_IN, ALU_SOURCE_IN,
                     ALU_OP_IN, REG_WRITE_IN, BRANCH_IN, PC_SEL_IN};
  assign w_dat_in = {PC_IN, RS1_DATA_IN, RS2_DATA_IN, IMM_IN, RD_IN, RS1_IN, RS2_IN};
  assign {MEM_READ_OUT, MEM_WRITE_OUT, MEM_TO_REG_OUT, ALU_SOURCE_OUT,
          ALU_OP_OUT, REG_WRITE_OUT, BRANCH_OUT, PC_SEL_OUT} = r_ctl;
  assign {PC_OUT, RS1_DATA_OUT, RS2_DATA_OUT, IMM_OUT, RD_OUT, RS1_OUT, RS2_OUT} = r_dat;
  assign VALID_OUT  = r_valid;
  assign BUBBLE_CNT = r_cnt;
  // rs2 only matters when the ALU reads it or a store sends it to memory
  assign w_rs2_used = (ALU_SOURCE_IN == 2'b00) | (MEM_WRITE_IN != 3'd0);
  assign w_hazard   = VALID_OUT & (MEM_READ_OUT != 3'd0) & REG_WRITE_OUT & (RD_OUT != 5'd0) &
                      IN_VALID & ((RS1_IN == RD_OUT) | ((RS2_IN == RD_OUT) & w_rs2_used));
  assign STALL_UP   = HOLD | (w_hazard & ~FLUSH);
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_ctl   <= '0;
      r_dat   <= '0;
      r_valid <= 1'b0;
      r_cnt   <= '0;
    end else if (!HOLD) begin
      if (FLUSH | w_hazard) begin
        r_ctl   <= '0;
        r_dat   <= '0;
        r_valid <= 1'b0;
      end else begin
        r_ctl   <= IN_VALID ? w_ctl_in : '0;
        r_dat   <= w_dat_in;
        r_valid <= IN_VALID;
      end
      if (!FLUSH && w_hazard && !(&r_cnt)) r_cnt <= r_cnt + CNT_W'(1);
    end
  end
endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register directly downstream of the decode control unit.
- Captures decoded control fields, operands, immediate, PC and register addresses each cycle and presents them to the execute stage.
- Contains load-use hazard detection, bubble insertion, flush, downstream hold, and a saturating bubble counter.
- A single clock `CLK`; `RESET` is synchronous and active-high.

Parameters:
- DATA_W, 32, operand/PC/immediate width
- CNT_W, 16, bubble performance counter width

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RESET  in  1  synchronous active-high reset
- HOLD  in  1  downstream busy (multi-cycle ALU/memory); freeze register
- FLUSH  in  1  branch/jump taken; replace captured instruction with bubble
- IN_VALID  in  1  IF/ID holds a real instruction
- MEM_READ_IN, MEM_WRITE_IN  in  3 each  load/store size codes from control unit
- MEM_TO_REG_IN, ALU_SOURCE_IN  in  2 each  control unit fields
- ALU_OP_IN  in  5  ALU operation code
- REG_WRITE_IN, BRANCH_IN, PC_SEL_IN  in  1 each  control unit fields
- PC_IN, RS1_DATA_IN, RS2_DATA_IN, IMM_IN  in  DATA_W each  decode datapath values
- RD_IN, RS1_IN, RS2_IN  in  5 each  register addresses
- *_OUT (one per *_IN above, same width)  out  registered copies
- VALID_OUT  out  1  execute stage holds a real instruction
- STALL_UP  out  1  combinational; IF and IF/ID must not advance
- BUBBLE_CNT  out  CNT_W  saturating count of inserted load-use bubbles

Behaviour:
- Reset (RESET=1 at edge): every *_OUT, VALID_OUT and BUBBLE_CNT = 0. This all-zero state is the canonical bubble: no register write, no memory access, no branch, ALU_OP add.
- Hazard (combinational): hazard = VALID_OUT & (MEM_READ_OUT!=0) & REG_WRITE_OUT & (RD_OUT!=0) & IN_VALID & (match1 | match2).
  - match1 = (RS1_IN==RD_OUT).
  - match2 = (RS2_IN==RD_OUT) & rs2_used.
  - rs2_used = (ALU_SOURCE_IN==2'b00) | (MEM_WRITE_IN!=0).
- STALL_UP = HOLD | (hazard & ~FLUSH).
- Edge update priority, highest first:
  - RESET: clear all.
  - HOLD: retain every output, including BUBBLE_CNT.
  - FLUSH: load bubble, VALID_OUT=0. FLUSH wins over hazard; no bubble counted.
  - hazard: load bubble, VALID_OUT=0, BUBBLE_CNT+1. Saturates at all-ones; no wrap.
  - else: capture all *_IN into *_OUT, VALID_OUT=IN_VALID. If IN_VALID=0, control fields are loaded as bubble values; data fields are still captured.
- Latency: 1 cycle, input to output.
- A load-use stall lasts exactly 1 cycle. After the bubble, MEM_READ_OUT=0, so hazard deasserts and the held IF/ID instruction enters on the next edge.
- HOLD during a pending hazard: the register freezes and STALL_UP stays high. The bubble is inserted on the first edge after HOLD drops.
- FLUSH and HOLD together: HOLD wins; the flush must be re-presented by the branch unit while HOLD is high.
- RESET mid-stall or mid-hold: immediate clear on that edge. STALL_UP follows the cleared state next cycle.
- RD_OUT=x0 never triggers a hazard. No forwarding is performed in this block.

Test Plan:
1. Reset then pass-through: RESET 1 cycle, then add x3,x1,x2 (ALU_OP=00000, RD=3, REG_WRITE=1) with IN_VALID=1 -> next cycle RD_OUT=3, ALU_OP_OUT=0, VALID_OUT=1, STALL_UP=0.
2. Load-use on rs1: lw x5 (MEM_READ=011, RD=5) then addi x6,x5,4 -> STALL_UP=1 for exactly 1 cycle; one bubble (VALID_OUT=0, REG_WRITE_OUT=0); addi appears the following cycle; BUBBLE_CNT=1.
3. No false stall: lw x5 then addi x6,x7,4 with RS2_IN=5 and ALU_SOURCE_IN=01 -> STALL_UP=0, no bubble. Also lw x0 then use x0 -> no stall.
4. HOLD during hazard: lw x5, then addi x6,x5,1 with HOLD=1 for 3 cycles -> outputs frozen, STALL_UP=1 throughout; bubble is inserted one edge after HOLD falls; BUBBLE_CNT increments once.
5. FLUSH with simultaneous hazard: lw x5 in EX, use of x5 in ID, FLUSH=1 -> bubble loaded, BUBBLE_CNT unchanged, STALL_UP=0.
6. Counter saturation: with CNT_W=4, force 17 load-use bubbles -> BUBBLE_CNT holds at 15. Then RESET -> all outputs 0.
